// File: rtl/idma_arb_pkg.sv
// Shared types and constants for the iDMA job arbiter slice.
package idma_arb_pkg;

  localparam int unsigned DefaultNumChan      = 4;
  localparam int unsigned DefaultMaxInFlight  = 8;
  localparam int unsigned DefaultDoneCntWidth = 32;

  typedef logic [$clog2(DefaultNumChan)-1:0] chan_idx_t;

  // Counter wide enough to hold 0..max_in_flight inclusive.
  function automatic int unsigned outstanding_width(input int unsigned max_in_flight);
    return $clog2(max_in_flight + 1);
  endfunction

endpackage

// File: rtl/idma_arb_owner_fifo.sv
// In-order FIFO that remembers which channel owns each job accepted by the back-end.
module idma_arb_owner_fifo
  import idma_arb_pkg::*;
#(
  parameter int unsigned Depth  = DefaultMaxInFlight,
  parameter type         data_t = chan_idx_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  data_t data,
  input  logic  pop,
  output data_t head,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = outstanding_width(Depth);

  data_t               mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [CntWidth-1:0] count;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CntWidth'(Depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PtrWidth'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PtrWidth'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CntWidth'(do_push) - CntWidth'(do_pop);
    end
  end

endmodule

// File: rtl/idma_job_arbiter.sv
// Round-robin sharing of one iDMA back-end between NumChan requesters,
// with in-order response routing and per-channel busy/completion tracking.
module idma_job_arbiter
  import idma_arb_pkg::*;
#(
  parameter int unsigned NumChan      = DefaultNumChan,
  parameter int unsigned MaxInFlight  = DefaultMaxInFlight,
  parameter int unsigned DoneCntWidth = DefaultDoneCntWidth,
  parameter type         idma_req_t   = logic,
  parameter type         idma_rsp_t   = logic,
  parameter int unsigned ChanIdxWidth = $clog2(NumChan)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  idma_req_t               req_i       [NumChan],
  input  logic [NumChan-1:0]      req_valid_i,
  output logic [NumChan-1:0]      req_ready_o,
  output idma_rsp_t               rsp_o       [NumChan],
  output logic [NumChan-1:0]      rsp_valid_o,
  input  logic [NumChan-1:0]      rsp_ready_i,
  output idma_req_t               be_req_o,
  output logic                    be_valid_o,
  input  logic                    be_ready_i,
  input  idma_rsp_t               be_rsp_i,
  input  logic                    be_rsp_valid_i,
  output logic                    be_rsp_ready_o,
  output logic [NumChan-1:0]      busy_o,
  output logic [DoneCntWidth-1:0] done_cnt_o  [NumChan],
  output logic                    orphan_rsp_o
);

  localparam int unsigned OutWidth = outstanding_width(MaxInFlight);

  typedef logic [ChanIdxWidth-1:0] chan_t;

  chan_t               rr_ptr;
  chan_t               rr_pick;
  chan_t               cand;
  chan_t               grant;
  chan_t               lock_chan;
  chan_t               head;
  logic                found;
  logic                lock_q;
  logic                any_valid;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                orphan_evt;
  logic [OutWidth-1:0] outstanding [NumChan];

  // First valid channel at or after the round-robin pointer.
  always_comb begin
    rr_pick = rr_ptr;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NumChan; i++) begin
      cand = ChanIdxWidth'((32'(rr_ptr) + i) % NumChan);
      if (!found && req_valid_i[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  end

  assign any_valid  = |req_valid_i;
  assign grant      = lock_q ? lock_chan : rr_pick;
  assign be_valid_o = rst_ni & any_valid & ~fifo_full;
  assign be_req_o   = req_i[grant];
  assign push       = be_valid_o & be_ready_i;

  // An empty owner FIFO means any response is an orphan: swallow it.
  assign be_rsp_ready_o = rst_ni & (fifo_empty ? be_rsp_valid_i : rsp_ready_i[head]);
  assign pop            = be_rsp_valid_i & be_rsp_ready_o & ~fifo_empty;
  assign orphan_evt     = be_rsp_valid_i & be_rsp_ready_o & fifo_empty;

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (push) begin
      req_ready_o[grant] = 1'b1;
    end
    if (rst_ni && be_rsp_valid_i && !fifo_empty) begin
      rsp_valid_o[head] = 1'b1;
    end
    for (int c = 0; c < NumChan; c++) begin
      rsp_o[c]  = be_rsp_i;
      busy_o[c] = (outstanding[c] != '0);
    end
  end

  idma_arb_owner_fifo #(
    .Depth  (MaxInFlight),
    .data_t (chan_t)
  ) i_owner_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .data  (grant),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Lock holds the grant while a job waits on be_ready_i so be_req_o stays stable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr       <= '0;
      lock_q       <= 1'b0;
      lock_chan    <= '0;
      orphan_rsp_o <= 1'b0;
      for (int c = 0; c < NumChan; c++) begin
        outstanding[c] <= '0;
        done_cnt_o[c]  <= '0;
      end
    end else begin
      lock_q    <= be_valid_o & ~be_ready_i;
      lock_chan <= grant;
      if (push) begin
        rr_ptr <= (grant == chan_t'(NumChan - 1)) ? '0 : grant + 1'b1;
      end
      if (orphan_evt) begin
        orphan_rsp_o <= 1'b1;
      end
      for (int c = 0; c < NumChan; c++) begin
        if (push && grant == chan_t'(c) && !(pop && head == chan_t'(c))) begin
          outstanding[c] <= outstanding[c] + 1'b1;
        end else if (pop && head == chan_t'(c) && !(push && grant == chan_t'(c))) begin
          outstanding[c] <= outstanding[c] - 1'b1;
        end
        if (pop && head == chan_t'(c)) begin
          done_cnt_o[c] <= done_cnt_o[c] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_idma_job_arbiter.sv
// Self-checking bench for idma_job_arbiter: queue-based reference model,
// directed scenarios and a randomized protocol-compliant phase.
module tb_idma_job_arbiter;

  localparam int unsigned NumChan      = 4;
  localparam int unsigned MaxInFlight  = 8;
  localparam int unsigned DoneCntWidth = 4;

  typedef logic [15:0] req_t;
  typedef logic [15:0] rsp_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  req_t                    req       [NumChan];
  logic [NumChan-1:0]      req_valid;
  logic [NumChan-1:0]      req_ready;
  rsp_t                    rsp       [NumChan];
  logic [NumChan-1:0]      rsp_valid;
  logic [NumChan-1:0]      rsp_ready;
  req_t                    be_req;
  logic                    be_valid;
  logic                    be_ready;
  rsp_t                    be_rsp;
  logic                    be_rsp_valid;
  logic                    be_rsp_ready;
  logic [NumChan-1:0]      busy;
  logic [DoneCntWidth-1:0] done_cnt  [NumChan];
  logic                    orphan;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owner queue plus plain per-channel integers.
  int model_q[$];
  int model_out  [NumChan];
  int model_done [NumChan];
  int model_rr     = 0;
  int model_lock   = -1;
  bit model_orphan = 1'b0;
  int grant_log[$];
  int rsp_owner_log[$];

  logic [NumChan-1:0] req_hs = '0;
  logic               rsp_hs = 1'b0;
  int                 be_pending = 0;
  bit                 chk_en = 1'b0;
  bit                 rand_mode = 1'b0;
  bit                 auto_rsp = 1'b0;
  logic [NumChan-1:0] chan_en = '0;

  always #5 clk = ~clk;

  idma_job_arbiter #(
    .NumChan      (NumChan),
    .MaxInFlight  (MaxInFlight),
    .DoneCntWidth (DoneCntWidth),
    .idma_req_t   (req_t),
    .idma_rsp_t   (rsp_t)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .rsp_o          (rsp),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .be_req_o       (be_req),
    .be_valid_o     (be_valid),
    .be_ready_i     (be_ready),
    .be_rsp_i       (be_rsp),
    .be_rsp_valid_i (be_rsp_valid),
    .be_rsp_ready_o (be_rsp_ready),
    .busy_o         (busy),
    .done_cnt_o     (done_cnt),
    .orphan_rsp_o   (orphan)
  );

  task automatic check_output(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict outputs from current inputs, compare, then advance the model past the edge.
  always @(negedge clk) begin
    bit                 any;
    bit                 full;
    bit                 empty;
    bit                 e_bv;
    bit                 e_brr;
    bit                 push;
    bit                 pop;
    int                 g;
    int                 head;
    logic [NumChan-1:0] e_rdy;
    logic [NumChan-1:0] e_rv;
    logic [NumChan-1:0] e_busy;

    any   = (req_valid != '0);
    full  = (model_q.size() == MaxInFlight);
    empty = (model_q.size() == 0);
    g = 0;
    if (model_lock >= 0) begin
      g = model_lock;
    end else begin
      for (int i = NumChan - 1; i >= 0; i--) begin
        if (req_valid[(model_rr + i) % NumChan]) g = (model_rr + i) % NumChan;
      end
    end
    e_bv  = rst_n && any && !full;
    e_rdy = '0;
    if (e_bv && be_ready) e_rdy[g] = 1'b1;
    head = empty ? 0 : model_q[0];
    e_rv = '0;
    if (rst_n && !empty && be_rsp_valid) e_rv[head] = 1'b1;
    e_brr = rst_n && (empty ? be_rsp_valid : rsp_ready[head]);
    for (int c = 0; c < NumChan; c++) e_busy[c] = (model_out[c] != 0);

    if (chk_en) begin
      check_output("be_valid", be_valid, e_bv);
      check_output("req_ready", req_ready, e_rdy);
      check_output("rsp_valid", rsp_valid, e_rv);
      check_output("be_rsp_ready", be_rsp_ready, e_brr);
      check_output("busy", busy, e_busy);
      check_output("orphan", orphan, model_orphan);
      for (int c = 0; c < NumChan; c++) begin
        check_output($sformatf("done_cnt[%0d]", c), done_cnt[c], model_done[c]);
      end
      if (e_bv) check_output("be_req", be_req, req[g]);
      if (e_rv != '0) check_output("rsp_data", rsp[head], be_rsp);
    end

    req_hs = req_valid & req_ready;
    rsp_hs = be_rsp_valid & be_rsp_ready;
    if (!rst_n) be_pending = 0;
    else be_pending += int'(be_valid && be_ready) - int'(rsp_hs && rsp_valid != '0);

    push = e_bv && be_ready;
    pop  = rst_n && !empty && be_rsp_valid && rsp_ready[head];
    if (!rst_n) begin
      model_q.delete();
      model_rr     = 0;
      model_lock   = -1;
      model_orphan = 1'b0;
      for (int c = 0; c < NumChan; c++) begin
        model_out[c]  = 0;
        model_done[c] = 0;
      end
    end else begin
      if (pop) begin
        void'(model_q.pop_front());
        model_out[head]--;
        model_done[head] = (model_done[head] + 1) % (1 << DoneCntWidth);
        rsp_owner_log.push_back(head);
      end
      if (empty && be_rsp_valid) model_orphan = 1'b1;
      if (push) begin
        model_q.push_back(g);
        model_out[g]++;
        model_rr = (g + 1) % NumChan;
        grant_log.push_back(g);
      end
      model_lock = (e_bv && !be_ready) ? g : -1;
    end
  end

  // One clock of stimulus; valids are only changed when idle or just accepted.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    for (int c = 0; c < NumChan; c++) begin
      if (!req_valid[c] || req_hs[c]) begin
        req_valid[c] = rand_mode ? ($urandom_range(0, 2) != 0) : chan_en[c];
        req[c]       = 16'($urandom);
      end
    end
    if (auto_rsp && (!be_rsp_valid || rsp_hs)) begin
      be_rsp_valid = (be_pending > 0) && (!rand_mode || $urandom_range(0, 1) == 1);
      be_rsp       = 16'($urandom);
    end
    if (rand_mode) begin
      be_ready  = ($urandom_range(0, 3) != 0);
      rsp_ready = 4'($urandom);
    end
    #1;
  endtask

  task automatic issue(input int c);
    int n;
    int k;
    n = grant_log.size();
    k = 0;
    chan_en = 4'(1 << c);
    while (grant_log.size() == n && k < 50) begin
      apply_stimulus();
      chan_en = '0;
      k++;
    end
    chan_en = '0;
    check_output($sformatf("issue_%0d_timeout", c), k < 50, 1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    auto_rsp  = 1'b1;
    rsp_ready = '1;
    be_ready  = 1'b1;
    while ((be_pending != 0 || req_valid != '0) && k < 300) begin
      apply_stimulus();
      k++;
    end
    check_output({tag, "_drain_timeout"}, k < 300, 1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    apply_stimulus();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int   n0;
    int   m0;
    req_t saved;

    rst_n        = 1'b0;
    req_valid    = '0;
    be_ready     = 1'b0;
    be_rsp_valid = 1'b0;
    be_rsp       = '0;
    rsp_ready    = '0;
    for (int c = 0; c < NumChan; c++) req[c] = '0;
    @(posedge clk);
    chk_en = 1'b1;
    apply_stimulus();
    rst_n = 1'b1;
    #1;
    check_output("reset_busy", busy, 0);
    check_output("reset_be_valid", be_valid, 0);
    check_output("reset_orphan", orphan, 0);

    // All channels valid, back-end always ready: round-robin until full.
    be_ready = 1'b1;
    chan_en  = '1;
    n0 = grant_log.size();
    repeat (12) apply_stimulus();
    chan_en = '0;
    check_output("full_grant_count", grant_log.size() - n0, 8);
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("rr_grant_%0d", i), grant_log[n0 + i], i % 4);
    end
    check_output("full_be_valid", be_valid, 0);
    check_output("full_busy", busy, 4'hF);
    drain("rr");
    for (int c = 0; c < NumChan; c++) begin
      check_output($sformatf("rr_done_%0d", c), done_cnt[c], 3);
    end

    // Lock: channel 2 stalled, channel 0 joins but must not steal the grant.
    pulse_reset();
    auto_rsp = 1'b0;
    be_ready = 1'b0;
    chan_en  = 4'b0100;
    apply_stimulus();
    saved = req[2];
    apply_stimulus();
    chan_en = 4'b0101;
    repeat (3) begin
      apply_stimulus();
      check_output("lock_be_req", be_req, saved);
      check_output("lock_req_ready", req_ready, 0);
      check_output("lock_be_valid", be_valid, 1);
    end
    chan_en  = '0;
    be_ready = 1'b1;
    n0 = grant_log.size();
    repeat (3) apply_stimulus();
    check_output("lock_first", grant_log[n0], 2);
    check_output("lock_second", grant_log[n0 + 1], 0);
    drain("lock");

    // Issue 1,3,1 and route responses back in order.
    pulse_reset();
    auto_rsp = 1'b0;
    be_ready = 1'b1;
    issue(1);
    issue(3);
    issue(1);
    m0 = rsp_owner_log.size();
    drain("order");
    check_output("order_rsp0", rsp_owner_log[m0], 1);
    check_output("order_rsp1", rsp_owner_log[m0 + 1], 3);
    check_output("order_rsp2", rsp_owner_log[m0 + 2], 1);
    check_output("order_done1", done_cnt[1], 2);
    check_output("order_done3", done_cnt[3], 1);
    check_output("order_busy", busy, 0);

    // Channel 3 refuses its response at the FIFO head: back-end stalls.
    auto_rsp = 1'b0;
    issue(3);
    issue(0);
    rsp_ready = 4'b0111;
    auto_rsp  = 1'b1;
    repeat (4) apply_stimulus();
    check_output("stall_be_rsp_ready", be_rsp_ready, 0);
    check_output("stall_rsp_valid", rsp_valid, 4'b1000);
    check_output("stall_done3", done_cnt[3], 1);
    drain("stall");
    check_output("stall_done3_after", done_cnt[3], 2);
    check_output("stall_done0_after", done_cnt[0], 1);

    // Orphan response with nothing outstanding.
    auto_rsp = 1'b0;
    check_output("orphan_before", orphan, 0);
    be_rsp_valid = 1'b1;
    be_rsp       = 16'hBEEF;
    #1;
    check_output("orphan_accept", be_rsp_ready, 1);
    check_output("orphan_no_route", rsp_valid, 0);
    apply_stimulus();
    be_rsp_valid = 1'b0;
    repeat (3) apply_stimulus();
    check_output("orphan_sticky", orphan, 1);
    check_output("orphan_done1", done_cnt[1], 2);
    check_output("orphan_busy", busy, 0);

    // Reset with five jobs in flight, then check the pointer restarted at 0.
    issue(1);
    issue(2);
    issue(3);
    issue(0);
    issue(1);
    check_output("inflight_busy", busy, 4'hF);
    pulse_reset();
    check_output("midreset_busy", busy, 0);
    check_output("midreset_orphan", orphan, 0);
    for (int c = 0; c < NumChan; c++) begin
      check_output($sformatf("midreset_done_%0d", c), done_cnt[c], 0);
    end
    chan_en = 4'b1010;
    n0 = grant_log.size();
    apply_stimulus();
    chan_en = '0;
    repeat (2) apply_stimulus();
    check_output("post_reset_first", grant_log[n0], 1);
    check_output("post_reset_second", grant_log[n0 + 1], 3);
    drain("postreset");

    // Completion counter wraps modulo 2^DoneCntWidth.
    auto_rsp = 1'b1;
    repeat (16) issue(0);
    drain("wrap");
    check_output("wrap_done0", done_cnt[0], 0);
    issue(0);
    drain("wrap2");
    check_output("wrap_done0_next", done_cnt[0], 1);

    // Randomized traffic with one reset in the middle.
    rand_mode = 1'b1;
    auto_rsp  = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) rst_n = 1'b0;
      if (i == 701) rst_n = 1'b1;
      apply_stimulus();
    end
    rand_mode = 1'b0;
    chan_en   = '0;
    drain("random");
    check_output("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/idma_job_arbiter.md
Name: idma_job_arbiter

Overview:
Shares one iDMA back-end between NumChan independent job requesters, such as per-core register front-ends or mid-ends. It grants 1D jobs round-robin. It records the owner of every accepted job in an in-order owner FIFO. It routes each back-end response to the channel that issued the job, and keeps per-channel outstanding and completion counters for busy reporting and ID retirement. It sits between the job FIFOs/front-ends and idma_backend_rw_axi.

Parameters:
NumChan, 4, number of requester channels (>=2)
MaxInFlight, 8, maximum jobs accepted by the back-end but not yet responded (power of two)
DoneCntWidth, 32, width of per-channel completion counters
idma_req_t, logic, back-end request type
idma_rsp_t, logic, back-end response type
ChanIdxWidth, $clog2(NumChan), derived; do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
req_i  in  NumChan x idma_req_t  per-channel job
req_valid_i  in  NumChan  per-channel job valid
req_ready_o  out  NumChan  per-channel job ready
rsp_o  out  NumChan x idma_rsp_t  per-channel response (broadcast of be_rsp_i)
rsp_valid_o  out  NumChan  per-channel response valid
rsp_ready_i  in  NumChan  per-channel response ready
be_req_o  out  idma_req_t  job to back-end
be_valid_o  out  1  back-end job valid
be_ready_i  in  1  back-end job ready
be_rsp_i  in  idma_rsp_t  back-end response
be_rsp_valid_i  in  1  back-end response valid
be_rsp_ready_o  out  1  back-end response ready
busy_o  out  NumChan  channel has outstanding jobs
done_cnt_o  out  NumChan x DoneCntWidth  responses delivered per channel
orphan_rsp_o  out  1  sticky: a response arrived with no recorded owner

Behaviour:
- Reset is synchronous. On reset, and when reset is asserted mid-operation, all of the following are cleared: owner FIFO empty, rr pointer = 0, lock cleared, outstanding counters = 0, done_cnt_o = 0, orphan_rsp_o = 0. In-flight back-end jobs are abandoned.
- Reset output values: be_valid_o=0, req_ready_o=0, rsp_valid_o=0, busy_o=0, be_rsp_ready_o=0 while owner FIFO empty.
- Arbitration:
  - Pick the first valid channel at or after the rr pointer, wrapping modulo NumChan.
  - Arbitration is combinational; job acceptance has zero latency.
  - be_valid_o = any valid & !fifo_full.
  - req_ready_o[g] = be_ready_i & !fifo_full for granted g only; 0 for all others.
- Lock: once be_valid_o is high without be_ready_i, the grant is frozen until the handshake, even if a higher-priority channel becomes valid. be_req_o stays stable, as the stream protocol requires.
- On handshake with channel g: push g into the owner FIFO, increment outstanding[g], set rr pointer = (g+1) mod NumChan, release the lock.
- Full: when the FIFO holds MaxInFlight entries, no grant is issued (be_valid_o=0). This holds even if a pop occurs in the same cycle, so full never depends combinationally on the response path.
- Response routing: the back-end responds in order. Owner o = FIFO head.
  - rsp_valid_o[o] = be_rsp_valid_i; all others 0.
  - be_rsp_ready_o = rsp_ready_i[o].
  - On handshake: pop, decrement outstanding[o], increment done_cnt_o[o]. The counter wraps modulo 2^DoneCntWidth.
- Orphan: if be_rsp_valid_i is high while the FIFO is empty, be_rsp_ready_o=1 and the response is dropped; orphan_rsp_o sets and stays set until reset.
- Simultaneous push and pop:
  - Same channel: outstanding is unchanged.
  - Push and pop on a non-empty, non-full FIFO: occupancy is unchanged.
- busy_o[c] = (outstanding[c] != 0), registered-counter based, with no combinational path from inputs.
- Outstanding counter width is $clog2(MaxInFlight+1) and never overflows, because it is bounded by the FIFO.

Decomposition:
- Package idma_arb_pkg holds the chan_idx_t typedef, a helper function computing outstanding-counter width, and the default constants.
- Sub-module idma_arb_owner_fifo: synchronous-reset FIFO of chan_idx_t, depth MaxInFlight, with push/pop/full/empty/head ports. The top holds the arbiter, lock and counters.

Test Plan:
- Channels 0-3 all valid, be_ready_i=1 every cycle -> grants 0,1,2,3,0,... one per cycle; FIFO reaches 8 entries, then be_valid_o=0 until the first response.
- Channel 2 valid, be_ready_i=0 for 5 cycles, channel 0 asserts valid at cycle 2 -> grant stays on 2 and be_req_o stays stable; channel 2 completes, then the next grant goes to 0.
- Issue 1,3,1 then return 3 responses -> rsp_valid_o pulses on 1,3,1 in order; done_cnt_o[1]=2, done_cnt_o[3]=1; busy_o returns to 0.
- Channel 3 holds rsp_ready_i=0 with its response at the FIFO head -> be_rsp_ready_o=0 and the back-end stalls; no other channel receives the response.
- Response with FIFO empty -> accepted, dropped, orphan_rsp_o=1 sticky; counters unchanged.
- rst_ni low for 1 cycle with 5 jobs in flight -> next cycle all counters 0, busy_o=0, FIFO empty, rr pointer 0; done_cnt_o preloaded at 2^32-1 wraps to 0 on the next response.
